alu_vector_driver: RTL and testbench

- Synthesizable stimulus-and-check engine for the 32-bit yAlu (ops AND/OR/ADD/SUB/SLT).
- It is the initiator side of the ALU operand/result interface: it generates pseudo-random operand/op vectors, drives them into the ALU, samples z and ex, and compares them against an internal golden model.
- Used for on-chip/bring-up self-test; the ALU instance sits beside it, driven only by this block.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_golden_model.sv | 32 +++
 rtl/alu_vector_driver.sv | 123 ++++++++++++
 tb/tb_alu_vector_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU self-test slice: op codes, FSM states and LFSR helpers.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN_A,
        ST_GEN_B,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Right-shifting Galois step; a non-zero state never reaches zero.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // Op mix is weighted towards arithmetic; entries 5..7 repeat AND/ADD/SUB.
    function automatic logic [2:0] op_from_sel(input logic [2:0] idx);
        logic [2:0] op;
        op = OP_AND;
        case (idx)
            3'd0: op = OP_AND;
            3'd1: op = OP_OR;
            3'd2: op = OP_ADD;
            3'd3: op = OP_SUB;
            3'd4: op = OP_SLT;
            3'd5: op = OP_AND;
            3'd6: op = OP_ADD;
            3'd7: op = OP_SUB;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference for the yAlu: expected z and zero flag for a given op.
module alu_golden_model
    import alu_pkg::*;
#(
    parameter bit SLT_SIGNED = 1'b0
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] expect_z,
    output logic        expect_zero
);

    logic lt;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        expect_z = '0;
        lt       = SLT_SIGNED ? ($signed(a) < $signed(b)) : (a < b);
        case (op)
            OP_AND:  expect_z = a & b;
            OP_OR:   expect_z = a | b;
            OP_ADD:  expect_z = a + b;
            OP_SUB:  expect_z = a - b;
            OP_SLT:  expect_z = {31'b0, lt};
            default: expect_z = '0;
        endcase
    end

    assign expect_zero = (expect_z == 32'd0);

endmodule

// File: rtl/alu_vector_driver.sv
// Self-test initiator for the yAlu: generates LFSR vectors, drives the ALU and checks z/ex.
module alu_vector_driver
    import alu_pkg::*;
#(
    parameter int          NUM_VECTORS   = 16,
    parameter logic [31:0] SEED          = 32'hACE1_2311,
    parameter int          SETTLE_CYCLES = 1,
    parameter bit          SLT_SIGNED    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_force_en,
    input  logic [2:0]  op_force,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_z,
    input  logic        alu_ex,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  vec_count,
    output logic [31:0] err_expect,
    output logic [31:0] err_got
);

    localparam logic [7:0]  LAST_COUNT  = 8'(NUM_VECTORS);
    localparam logic [15:0] SETTLE_INIT = 16'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [31:0] lfsr;
    logic [15:0] settle_cnt;
    logic [31:0] expect_z;
    logic        expect_zero;
    logic        mismatch;
    logic [7:0]  vec_next;

    alu_golden_model #(
        .SLT_SIGNED(SLT_SIGNED)
    ) u_golden (
        .a          (alu_a),
        .b          (alu_b),
        .op         (alu_op),
        .expect_z   (expect_z),
        .expect_zero(expect_zero)
    );

    assign mismatch = (alu_z != expect_z) || (alu_ex != expect_zero);
    assign vec_next = vec_count + 8'd1;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            lfsr       <= SEED;
            settle_cnt <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec_count  <= '0;
            err_expect <= '0;
            err_got    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_GEN_A;
                        lfsr      <= SEED;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        vec_count <= '0;
                    end
                end
                ST_GEN_A: begin
                    alu_a <= lfsr;
                    lfsr  <= lfsr_step(lfsr);
                    state <= ST_GEN_B;
                end
                ST_GEN_B: begin
                    // Even selector reuses A so the equal-operand corner is hit often.
                    alu_b      <= lfsr[0] ? lfsr : alu_a;
                    alu_op     <= op_force_en ? op_force : op_from_sel(lfsr[3:1]);
                    lfsr       <= lfsr_step(lfsr);
                    settle_cnt <= SETTLE_INIT;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == 16'd0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 16'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_expect <= expect_z;
                        err_got    <= alu_z;
                        pass       <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_DONE;
                    end else if (vec_next == LAST_COUNT) begin
                        vec_count <= vec_next;
                        pass      <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_DONE;
                    end else begin
                        vec_count <= vec_next;
                        state     <= ST_GEN_A;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_vector_driver.sv
// Scoreboard bench: stimulus queues expected run results, per-instance monitors compare on done.
module tb_alu_vector_driver;
    import alu_pkg::*;

    typedef enum int {F_NONE, F_SUB_ADD, F_EQ_EX0, F_ZERO} fault_t;

    typedef struct {
        logic        pass;
        logic [7:0]  vec_count;
        logic        chk_err;
        logic [31:0] err_expect;
        logic [31:0] err_got;
        int          latency;
        int          busy_cycles;
    } result_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance: default seed, unsigned SLT
    logic        m_start = 1'b0, m_force_en = 1'b0;
    logic [2:0]  m_force = 3'b000;
    logic [31:0] m_a, m_b, m_z, m_ee, m_eg;
    logic [2:0]  m_op;
    logic        m_ex, m_busy, m_done, m_pass;
    logic [7:0]  m_vc;
    fault_t      fault_main = F_NONE;

    // Aux pair: same seed/settle, one unsigned and one signed SLT golden model
    logic        x_start = 1'b0;
    logic [31:0] u_a, u_b, u_z, u_ee, u_eg, s_a, s_b, s_z, s_ee, s_eg;
    logic [2:0]  u_op, s_op;
    logic        u_ex, u_busy, u_done, u_pass, s_ex, s_busy, s_done, s_pass;
    logic [7:0]  u_vc, s_vc;
    fault_t      fault_aux = F_NONE;
    bit          aux_alu_signed = 1'b0;

    alu_vector_driver #(.NUM_VECTORS(16), .SEED(32'hACE1_2311), .SETTLE_CYCLES(1), .SLT_SIGNED(1'b0)) u_main (
        .clk(clk), .reset(reset), .start(m_start), .op_force_en(m_force_en), .op_force(m_force),
        .alu_a(m_a), .alu_b(m_b), .alu_op(m_op), .alu_z(m_z), .alu_ex(m_ex),
        .busy(m_busy), .done(m_done), .pass(m_pass), .vec_count(m_vc), .err_expect(m_ee), .err_got(m_eg));

    alu_vector_driver #(.NUM_VECTORS(4), .SEED(32'h8000_0002), .SETTLE_CYCLES(2), .SLT_SIGNED(1'b0)) u_uns (
        .clk(clk), .reset(reset), .start(x_start), .op_force_en(1'b1), .op_force(3'b111),
        .alu_a(u_a), .alu_b(u_b), .alu_op(u_op), .alu_z(u_z), .alu_ex(u_ex),
        .busy(u_busy), .done(u_done), .pass(u_pass), .vec_count(u_vc), .err_expect(u_ee), .err_got(u_eg));

    alu_vector_driver #(.NUM_VECTORS(4), .SEED(32'h8000_0002), .SETTLE_CYCLES(2), .SLT_SIGNED(1'b1)) u_sgn (
        .clk(clk), .reset(reset), .start(x_start), .op_force_en(1'b1), .op_force(3'b111),
        .alu_a(s_a), .alu_b(s_b), .alu_op(s_op), .alu_z(s_z), .alu_ex(s_ex),
        .busy(s_busy), .done(s_done), .pass(s_pass), .vec_count(s_vc), .err_expect(s_ee), .err_got(s_eg));

    // Behavioural yAlu with injectable faults
    function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op, input bit sgn, input fault_t f);
        logic [31:0] z;
        logic        ex;
        z = '0;
        case (op)
            OP_AND:  z = a & b;
            OP_OR:   z = a | b;
            OP_ADD:  z = a + b;
            OP_SUB:  z = (f == F_SUB_ADD) ? (a + b) : (a - b);
            OP_SLT:  z = sgn ? {31'b0, $signed(a) < $signed(b)} : {31'b0, a < b};
            default: z = '0;
        endcase
        ex = (z == 32'd0);
        if (f == F_EQ_EX0 && a == b) ex = 1'b0;
        if (f == F_ZERO) begin
            z  = '0;
            ex = 1'b1;
        end
        return {ex, z};
    endfunction

    always_comb {m_ex, m_z} = alu_model(m_a, m_b, m_op, 1'b0, fault_main);
    always_comb {u_ex, u_z} = alu_model(u_a, u_b, u_op, aux_alu_signed, fault_aux);
    always_comb {s_ex, s_z} = alu_model(s_a, s_b, s_op, aux_alu_signed, fault_aux);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    task automatic compare(input string tag, input result_t e, input logic p, input logic [7:0] vc,
                           input logic [31:0] ee, input logic [31:0] eg, input int lat, input int bc);
        check({tag, ".pass"}, 32'(p), 32'(e.pass));
        check({tag, ".vec_count"}, 32'(vc), 32'(e.vec_count));
        if (e.chk_err) begin
            check({tag, ".err_expect"}, ee, e.err_expect);
            check({tag, ".err_got"}, eg, e.err_got);
        end
        check({tag, ".latency"}, 32'(lat), 32'(e.latency));
        if (e.busy_cycles >= 0) check({tag, ".busy_cycles"}, 32'(bc), 32'(e.busy_cycles));
    endtask

    result_t q_main[$], q_uns[$], q_sgn[$];
    result_t e_main, e_uns, e_sgn;
    int      start_main = 0, start_aux = 0, busy_main = 0;
    logic    m_done_q = 1'b0, u_done_q = 1'b0, s_done_q = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            busy_main = 0;
        end else begin
            if (m_busy) busy_main++;
            if (m_done && !m_done_q) begin
                if (q_main.size() == 0) begin
                    check("main.unexpected_done", 32'(m_done), 32'd0);
                end else begin
                    e_main = q_main.pop_front();
                    compare("main", e_main, m_pass, m_vc, m_ee, m_eg, cyc - start_main, busy_main);
                end
                busy_main = 0;
            end
        end
        m_done_q = m_done;
    end

    always @(negedge clk) begin
        if (!reset && u_done && !u_done_q) begin
            if (q_uns.size() == 0) begin
                check("uns.unexpected_done", 32'(u_done), 32'd0);
            end else begin
                e_uns = q_uns.pop_front();
                compare("uns", e_uns, u_pass, u_vc, u_ee, u_eg, cyc - start_aux, 0);
            end
        end
        u_done_q = u_done;
    end

    always @(negedge clk) begin
        if (!reset && s_done && !s_done_q) begin
            if (q_sgn.size() == 0) begin
                check("sgn.unexpected_done", 32'(s_done), 32'd0);
            end else begin
                e_sgn = q_sgn.pop_front();
                compare("sgn", e_sgn, s_pass, s_vc, s_ee, s_eg, cyc - start_aux, 0);
            end
        end
        s_done_q = s_done;
    end

    task automatic pulse_main();
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        start_main = cyc;
    endtask

    task automatic pulse_aux();
        x_start = 1'b1;
        @(negedge clk);
        x_start = 1'b0;
        start_aux = cyc;
    endtask

    task automatic wait_results(input string tag);
        int n = 0;
        while ((q_main.size() + q_uns.size() + q_sgn.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".timeout"}, 32'(q_main.size() + q_uns.size() + q_sgn.size()), 32'd0);
        q_main.delete();
        q_uns.delete();
        q_sgn.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, 32'(m_busy), 32'd0);
        check({tag, ".done"}, 32'(m_done), 32'd0);
        check({tag, ".pass"}, 32'(m_pass), 32'd0);
        check({tag, ".vec_count"}, 32'(m_vc), 32'd0);
        check({tag, ".alu_a"}, m_a, 32'd0);
        check({tag, ".alu_b"}, m_b, 32'd0);
        check({tag, ".alu_op"}, 32'(m_op), 32'd0);
        check({tag, ".err_expect"}, m_ee, 32'd0);
        check({tag, ".err_got"}, m_eg, 32'd0);
    endtask

    // Called right after pulse_main; leaves the bench at the negedge after edge 5 of the run.
    task automatic check_first_vectors(input string tag);
        @(negedge clk);
        check({tag, ".a0"}, m_a, 32'hACE1_2311);
        check({tag, ".busy"}, 32'(m_busy), 32'd1);
        @(negedge clk);
        check({tag, ".b0"}, m_b, 32'hD650_918B);
        check({tag, ".op0"}, 32'(m_op), 32'(OP_AND));
        repeat (3) @(negedge clk);
        check({tag, ".a1"}, m_a, 32'hEB08_48C6);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Correct ALU, full passing run
        q_main.push_back('{1'b1, 8'd16, 1'b0, 32'd0, 32'd0, 64, 64});
        pulse_main();
        check_first_vectors("run1");
        wait_results("run1");

        // SUB implemented as ADD: first vector fails
        fault_main = F_SUB_ADD;
        m_force_en = 1'b1;
        m_force = 3'b110;
        q_main.push_back('{1'b0, 8'd0, 1'b1, 32'hD690_9186, 32'h8331_B49C, 4, 4});
        pulse_main();
        wait_results("sub_fault");

        // Unsupported op 011: golden value is zero
        fault_main = F_ZERO;
        m_force = 3'b011;
        q_main.push_back('{1'b1, 8'd16, 1'b0, 32'd0, 32'd0, 64, 64});
        pulse_main();
        wait_results("op011");

        // start while busy is ignored
        fault_main = F_NONE;
        m_force_en = 1'b0;
        q_main.push_back('{1'b1, 8'd16, 1'b0, 32'd0, 32'd0, 64, 64});
        pulse_main();
        repeat (4) @(negedge clk);
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        wait_results("restart_ignored");

        // Reset at cycle 10 aborts; a fresh run reproduces the operand sequence
        pulse_main();
        check_first_vectors("pre_reset");
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        q_main.push_back('{1'b1, 8'd16, 1'b0, 32'd0, 32'd0, 64, 64});
        pulse_main();
        check_first_vectors("post_reset");
        wait_results("post_reset");

        // Forced SLT, ALU drops ex on equal operands (vector 1 has a==b)
        fault_aux = F_EQ_EX0;
        aux_alu_signed = 1'b0;
        q_uns.push_back('{1'b0, 8'd1, 1'b1, 32'd0, 32'd0, 10, -1});
        q_sgn.push_back('{1'b0, 8'd0, 1'b1, 32'd1, 32'd0, 5, -1});
        pulse_aux();
        wait_results("slt_eq");

        // Signed ALU: a=0x80000002, b=0x40000001 -> signed expects 1, unsigned expects 0
        fault_aux = F_NONE;
        aux_alu_signed = 1'b1;
        q_uns.push_back('{1'b0, 8'd0, 1'b1, 32'd0, 32'd1, 5, -1});
        q_sgn.push_back('{1'b1, 8'd4, 1'b0, 32'd0, 32'd0, 20, -1});
        pulse_aux();
        wait_results("slt_signed");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
